// File: rtl/base_aburp_pipe.sv
// rtl/base_aburp_pipe.sv - elastic valid/ready pipeline with a registered-ready skid entry stage
//
// Purpose:
//   Multi-stage valid/ready pipeline. A skid (burp) entry register drives
//   i_r from a flop, which breaks the backward ready path. It is followed by
//   `stages` output register stages, which break the forward valid/data path.
//   Full throughput, order preserved.
//
// Parameters:
//   width      payload bits
//   del_width  extra sideband bits, carried exactly like payload
//   stages     output register stages after the skid (1..8)
//
// Ports:
//   clk    in   clock
//   reset  in   asynchronous reset, active high
//   flush  in   synchronous flush, active high (only with BASE_ABURP_PIPE_FLUSH_EN)
//   i_v    in   input valid
//   i_d    in   input data, width+del_width bits
//   i_r    out  input ready, straight from a flop
//   o_v    out  output valid, straight from the last stage flop
//   o_d    out  output data, straight from the last stage flop
//   o_r    in   output ready
//   occ    out  entries held (skid + stages), 0..stages+1
//
// Configuration:
//   BASE_ABURP_PIPE_FLUSH_EN  adds the 'flush' input
module base_aburp_pipe #(
  parameter int width     = 1,
  parameter int del_width = 0,
  parameter int stages    = 2
) (
  input  logic                            clk,
  input  logic                            reset,
`ifdef BASE_ABURP_PIPE_FLUSH_EN
  input  logic                            flush,
`endif
  input  logic                            i_v,
  input  logic [width+del_width-1:0]      i_d,
  output logic                            i_r,
  output logic                            o_v,
  output logic [width+del_width-1:0]      o_d,
  input  logic                            o_r,
  output logic [$clog2(stages+2)-1:0]     occ
);

  localparam int DW = width + del_width;
  localparam int OW = $clog2(stages + 2);

  if (stages < 1 || stages > 8) begin : g_bad_stages
    $error("base_aburp_pipe: stages must be in 1..8");
  end

  logic                      skid_v_q, skid_v_d;
  logic [DW-1:0]             skid_d_q, skid_d_d;
  logic [stages-1:0]         stage_v_q, stage_v_d;
  logic [stages-1:0][DW-1:0] stage_d_q, stage_d_d;
  logic                      i_r_q, i_r_d;
  logic [OW-1:0]             occ_q, occ_d;

  logic [stages-1:0]         load;
  logic                      in_xfer;
  logic                      out_xfer;
  logic                      flush_now;

`ifdef BASE_ABURP_PIPE_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  // Stage k can take a new value when it is empty or its content moves on.
  // This ready chain runs combinationally from o_r back to stage 0 and stops
  // there; the skid turns it into the registered i_r.
  always_comb begin
    logic nxt;
    load     = '0;
    nxt      = o_r;
    for (int k = stages - 1; k >= 0; k--) begin
      load[k] = ~stage_v_q[k] | nxt;
      nxt     = load[k];
    end
    in_xfer  = i_v & i_r_q;
    out_xfer = stage_v_q[stages-1] & o_r;
  end

  always_comb begin
    logic          src_v;
    logic [DW-1:0] src_d;

    stage_v_d = stage_v_q;
    stage_d_d = stage_d_q;
    skid_v_d  = skid_v_q;
    skid_d_d  = skid_d_q;
    occ_d     = occ_q;

    // A held skid beat always goes ahead of new input.
    if (skid_v_q) begin
      src_v = 1'b1;
      src_d = skid_d_q;
    end else begin
      src_v = in_xfer;
      src_d = i_d;
    end

    // Data only updates with a valid source, so o_d stays put otherwise.
    if (load[0]) begin
      stage_v_d[0] = src_v;
      if (src_v) stage_d_d[0] = src_d;
    end
    for (int k = 1; k < stages; k++) begin
      if (load[k]) begin
        stage_v_d[k] = stage_v_q[k-1];
        if (stage_v_q[k-1]) stage_d_d[k] = stage_d_q[k-1];
      end
    end

    if (skid_v_q) begin
      if (load[0]) skid_v_d = 1'b0;
    end else if (in_xfer && !load[0]) begin
      skid_v_d = 1'b1;
      skid_d_d = i_d;
    end

    if (in_xfer && !out_xfer) begin
      occ_d = occ_q + OW'(1);
    end else if (!in_xfer && out_xfer) begin
      occ_d = occ_q - OW'(1);
    end

    if (flush_now) begin
      stage_v_d = '0;
      skid_v_d  = 1'b0;
      occ_d     = '0;
    end

    i_r_d = ~skid_v_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_v_q  <= 1'b0;
      skid_d_q  <= '0;
      stage_v_q <= '0;
      stage_d_q <= '0;
      i_r_q     <= 1'b1;
      occ_q     <= '0;
    end else begin
      skid_v_q  <= skid_v_d;
      skid_d_q  <= skid_d_d;
      stage_v_q <= stage_v_d;
      stage_d_q <= stage_d_d;
      i_r_q     <= i_r_d;
      occ_q     <= occ_d;
    end
  end

  assign i_r = i_r_q;
  assign o_v = stage_v_q[stages-1];
  assign o_d = stage_d_q[stages-1];
  assign occ = occ_q;

endmodule

// File: tb/tb_base_aburp_pipe.sv
// tb/tb_base_aburp_pipe.sv - self-checking bench for base_aburp_pipe
module tb_base_aburp_pipe;

  logic        clk = 1'b0;
  logic        reset;
`ifdef BASE_ABURP_PIPE_FLUSH_EN
  logic        flush;
`endif

  // DUT A: stages=2, 8-bit payload
  logic        a_iv, a_ir, a_ov, a_or;
  logic [7:0]  a_id, a_od;
  logic [1:0]  a_occ;

  // DUT B: stages=3, 8-bit payload + 4 sideband bits
  logic        b_iv, b_ir, b_ov, b_or;
  logic [11:0] b_id, b_od;
  logic [2:0]  b_occ;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  base_aburp_pipe #(.width(8), .del_width(0), .stages(2)) u_dut_a (
    .clk(clk), .reset(reset),
`ifdef BASE_ABURP_PIPE_FLUSH_EN
    .flush(flush),
`endif
    .i_v(a_iv), .i_d(a_id), .i_r(a_ir),
    .o_v(a_ov), .o_d(a_od), .o_r(a_or), .occ(a_occ)
  );

  base_aburp_pipe #(.width(8), .del_width(4), .stages(3)) u_dut_b (
    .clk(clk), .reset(reset),
`ifdef BASE_ABURP_PIPE_FLUSH_EN
    .flush(flush),
`endif
    .i_v(b_iv), .i_d(b_id), .i_r(b_ir),
    .o_v(b_ov), .o_d(b_od), .o_r(b_or), .occ(b_occ)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       o_r;
    logic       ir;
    logic       ov;
    logic [7:0] od;
    logic [1:0] occ;
  } vec_t;

  vec_t        tbl[13];
  logic [11:0] q[$];
  int          idx, sent, cyc, acc, outs;
  logic        in_x, out_x, prev_hold;
  logic [11:0] prev_od;

  initial begin
    // Each row: inputs for this cycle, then the outputs expected before they are applied.
    tbl[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[1]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 2'd1};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 2'd2};
    tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h11, 2'd3};
    tbl[4]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h11, 2'd3};
    tbl[5]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h22, 2'd2};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 2'd2};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h44, 2'd1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 2'd1};
    tbl[9]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h55, 2'd1};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};

    reset = 1'b1;
`ifdef BASE_ABURP_PIPE_FLUSH_EN
    flush = 1'b0;
`endif
    a_iv = 1'b0; a_id = '0; a_or = 1'b0;
    b_iv = 1'b0; b_id = '0; b_or = 1'b0;
    repeat (2) tick();
    reset = 1'b0;

    chk("reset_b_ir", 32'(b_ir), 32'd1);
    chk("reset_b_ov", 32'(b_ov), 32'd0);
    chk("reset_b_occ", 32'(b_occ), 32'd0);

    // Table: fill, skid capture, full+drain, bubble through empty stages (DUT A).
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("tbl%0d_ir", i), 32'(a_ir), 32'(tbl[i].ir));
      chk($sformatf("tbl%0d_ov", i), 32'(a_ov), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_occ", i), 32'(a_occ), 32'(tbl[i].occ));
      if (tbl[i].ov) chk($sformatf("tbl%0d_od", i), 32'(a_od), 32'(tbl[i].od));
      a_iv = tbl[i].iv; a_id = tbl[i].d; a_or = tbl[i].o_r;
      tick();
    end

    // Streaming 0x01..0x10 with o_r=1 on DUT A.
    a_or = 1'b1;
    for (int c = 0; c < 20; c++) begin
      acc  = (c < 16) ? c : 16;
      outs = (c < 2) ? 0 : (((c - 2) < 16) ? (c - 2) : 16);
      chk($sformatf("strm%0d_occ", c), 32'(a_occ), 32'(acc - outs));
      chk($sformatf("strm%0d_ir", c), 32'(a_ir), 32'd1);
      if (c >= 2 && outs < 16) begin
        chk($sformatf("strm%0d_ov", c), 32'(a_ov), 32'd1);
        chk($sformatf("strm%0d_od", c), 32'(a_od), 32'(outs + 1));
      end else begin
        chk($sformatf("strm%0d_ov", c), 32'(a_ov), 32'd0);
      end
      a_iv = (c < 16);
      a_id = 8'(c + 1);
      tick();
    end
    a_iv = 1'b0; a_or = 1'b0;

    // Backpressure on DUT B (stages=3): 0xA0..0xA4 with o_r=0.
    b_or = 1'b0; idx = 0;
    for (int c = 0; c < 8; c++) begin
      b_iv = (idx < 5);
      b_id = 12'(8'hA0 + idx);
      in_x = b_iv & b_ir;
      tick();
      if (in_x) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd4);
    chk("bp_occ", 32'(b_occ), 32'd4);
    chk("bp_ir", 32'(b_ir), 32'd0);
    chk("bp_ov", 32'(b_ov), 32'd1);
    chk("bp_od", 32'(b_od), 32'h0A0);
    b_or = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_out%0d_ov", c), 32'(b_ov), 32'd1);
      chk($sformatf("bp_out%0d_od", c), 32'(b_od), 32'(12'h0A0 + c));
      b_iv = (idx < 5);
      b_id = 12'(8'hA0 + idx);
      in_x = b_iv & b_ir;
      tick();
      if (in_x) idx++;
    end
    b_iv = 1'b0;
    chk("bp_all_in", 32'(idx), 32'd5);
    chk("bp_empty_ov", 32'(b_ov), 32'd0);
    chk("bp_empty_occ", 32'(b_occ), 32'd0);

    // Full with simultaneous o_r=1 and i_v=1 on DUT B.
    b_or = 1'b0;
    for (int c = 0; c < 5; c++) begin
      b_iv = 1'b1; b_id = 12'(12'hB00 + c);
      tick();
    end
    chk("full_occ", 32'(b_occ), 32'd4);
    chk("full_ir", 32'(b_ir), 32'd0);
    b_or = 1'b1; b_iv = 1'b1; b_id = 12'hBFF;
    tick();
    b_iv = 1'b0;
    chk("fd_occ", 32'(b_occ), 32'd3);
    chk("fd_ir", 32'(b_ir), 32'd1);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("fd_out%0d", c), 32'(b_od), 32'(12'hB01 + c));
      tick();
    end
    chk("fd_empty_ov", 32'(b_ov), 32'd0);

    // Asynchronous reset mid-stream with occ=3 on DUT B.
    b_or = 1'b0;
    for (int c = 0; c < 3; c++) begin
      b_iv = 1'b1; b_id = 12'(12'hC00 + c);
      tick();
    end
    b_iv = 1'b0;
    chk("rst_pre_occ", 32'(b_occ), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("rst_ov", 32'(b_ov), 32'd0);
    chk("rst_ir", 32'(b_ir), 32'd1);
    chk("rst_occ", 32'(b_occ), 32'd0);
    tick();
    reset = 1'b0;
    b_or = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("rst_stale%0d", c), 32'(b_ov), 32'd0);
      tick();
    end

`ifdef BASE_ABURP_PIPE_FLUSH_EN
    // Flush with occ=3 while 0x55 is presented (DUT B, i_r still high).
    b_or = 1'b0;
    for (int c = 0; c < 3; c++) begin
      b_iv = 1'b1; b_id = 12'(12'hD00 + c);
      tick();
    end
    chk("fl_pre_occ", 32'(b_occ), 32'd3);
    flush = 1'b1; b_iv = 1'b1; b_id = 12'h055;
    tick();
    flush = 1'b0; b_iv = 1'b0;
    chk("fl_occ", 32'(b_occ), 32'd0);
    chk("fl_ov", 32'(b_ov), 32'd0);
    chk("fl_ir", 32'(b_ir), 32'd1);
    b_or = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("fl_none%0d", c), 32'(b_ov), 32'd0);
      tick();
    end
`endif

    // Random traffic on DUT B against a queue model.
    q.delete();
    sent = 0; cyc = 0; prev_hold = 1'b0; prev_od = '0;
    while (sent < 10000 && cyc < 60000) begin
      chk("rnd_occ", 32'(b_occ), 32'(q.size()));
      chk("rnd_ir", 32'(b_ir), 32'(q.size() != 4));
      if (q.size() == 0) chk("rnd_empty_ov", 32'(b_ov), 32'd0);
      if (b_ov && q.size() != 0) chk("rnd_od", 32'(b_od), 32'(q[0]));
      if (prev_hold) begin
        chk("rnd_hold_ov", 32'(b_ov), 32'd1);
        chk("rnd_hold_od", 32'(b_od), 32'(prev_od));
      end
      b_iv = 1'($urandom % 2);
      b_id = 12'($urandom);
      b_or = 1'($urandom % 2);
      in_x  = b_iv & b_ir;
      out_x = b_ov & b_or;
      prev_hold = b_ov & ~b_or;
      prev_od   = b_od;
      tick();
      if (out_x && q.size() != 0) void'(q.pop_front());
      if (in_x) begin
        q.push_back(b_id);
        sent++;
      end
      cyc++;
    end
    chk("rnd_sent", 32'(sent), 32'd10000);
    b_iv = 1'b0; b_or = 1'b1;
    for (int c = 0; c < 12 && q.size() != 0; c++) begin
      if (b_ov) begin
        chk("rnd_drain_od", 32'(b_od), 32'(q[0]));
        void'(q.pop_front());
      end
      tick();
    end
    chk("rnd_drained", 32'(q.size()), 32'd0);
    chk("rnd_final_occ", 32'(b_occ), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
